// File: rtl/eq_gain_regbank_ctrl.sv
// eq_gain_regbank_ctrl
// Turns the byte stream from i2c_slave into writes to a double-buffered
// equalizer band-gain bank. The first byte after START is a register pointer
// (addresses 1..NUM_BANDS). Each following byte writes the next shadow gain,
// and the pointer auto-increments. Shadow gains are copied into the active bank
// all at once on a sample boundary, so the filter never sees a partial update.
//
// Input protocol: i2c_start, i2c_data_valid and sample_tick are single-cycle
// pulses. There is no ready/backpressure path, so every accepted pulse is
// consumed in the cycle it is seen. When i2c_start and i2c_data_valid are high
// in the same cycle, START wins and the byte is ignored.
module eq_gain_regbank_ctrl #(
  parameter int                NUM_BANDS    = 10,
  parameter int                GAIN_W       = 8,
  parameter logic [GAIN_W-1:0] MAX_GAIN     = 8'd255,
  parameter int                IDLE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i2c_start,
  input  logic [7:0]                    i2c_data,
  input  logic                          i2c_data_valid,
  output logic [7:0]                    i2c_rd_data,
  input  logic                          sample_tick,
  input  logic                          err_clr,
  output logic [NUM_BANDS*GAIN_W-1:0]   gain_bus,
  output logic                          gains_updated,
  output logic                          busy,
  output logic                          err_range,
  output logic                          err_overflow
);

  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_PTR = 2'd1,
    ST_WRITE   = 2'd2
  } state_e;

  state_e                        state_q,      state_d;
  logic [CNT_W-1:0]              idle_cnt_q,   idle_cnt_d;
  logic [7:0]                    ptr_q,        ptr_d;
  logic                          ptr_valid_q,  ptr_valid_d;
  logic                          dirty_q,      dirty_d;
  logic [NUM_BANDS*GAIN_W-1:0]   shadow_q,     shadow_d;
  logic [NUM_BANDS*GAIN_W-1:0]   active_q,     active_d;
  logic                          upd_q,        upd_d;
  logic                          busy_q,       busy_d;
  logic                          err_range_q,  err_range_d;
  logic                          err_ovf_q,    err_ovf_d;
  logic [7:0]                    rd_data_q,    rd_data_d;

  logic                          commit;
  logic                          timeout;
  logic                          wr_en;
  logic                          range_evt;
  logic                          ovf_evt;
  logic                          ptr_in_bank;
  logic                          new_ptr_ok;
  logic [GAIN_W-1:0]             wr_val;

  // Next-state logic: transaction FSM, pointer, shadow/active banks, sticky errors
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ptr_valid_d = ptr_valid_q;
    wr_en       = 1'b0;
    range_evt   = 1'b0;
    ovf_evt     = 1'b0;

    // A commit needs the bus to be quiet; the START of a new transaction in the
    // same cycle still sees IDLE here, so that commit is not lost.
    commit      = (state_q == ST_IDLE) && dirty_q && sample_tick;
    timeout     = (idle_cnt_q == CNT_W'(IDLE_TIMEOUT));
    ptr_in_bank = (ptr_q != 8'd0) && (int'(ptr_q) <= NUM_BANDS);
    new_ptr_ok  = (i2c_data != 8'd0) && (int'(i2c_data) <= NUM_BANDS);

    if (int'(i2c_data) > int'(MAX_GAIN)) begin
      wr_val = MAX_GAIN;
    end else begin
      wr_val = GAIN_W'(i2c_data);
    end

    // Idle counter saturates so a long-idle bus never wraps back into activity
    if (i2c_start || i2c_data_valid) begin
      idle_cnt_d = '0;
    end else if (!timeout) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    if (i2c_start) begin
      state_d = ST_GET_PTR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_GET_PTR: begin
          if (i2c_data_valid) begin
            ptr_d       = i2c_data;
            ptr_valid_d = new_ptr_ok;
            range_evt   = !new_ptr_ok;
            state_d     = ST_WRITE;
          end else if (timeout) begin
            state_d = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (i2c_data_valid) begin
            // An invalid pointer was already flagged; its data is dropped quietly
            if (ptr_valid_q) begin
              if (ptr_in_bank) begin
                wr_en = 1'b1;
                ptr_d = ptr_q + 8'd1;
              end else begin
                ovf_evt = 1'b1;
              end
            end
          end else if (timeout) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    shadow_d = shadow_q;
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (wr_en && (int'(ptr_q) == k + 1)) begin
        shadow_d[k*GAIN_W +: GAIN_W] = wr_val;
      end
    end

    active_d = commit ? shadow_q : active_q;

    if (commit) begin
      dirty_d = 1'b0;
    end else if (wr_en) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end

    upd_d       = commit;
    busy_d      = (state_d != ST_IDLE) || dirty_d;
    // A new error event outranks a same-cycle clear
    err_range_d = range_evt || (err_range_q && !err_clr);
    err_ovf_d   = ovf_evt   || (err_ovf_q   && !err_clr);

    rd_data_d = 8'h00;
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (ptr_valid_q && (int'(ptr_q) == k + 1)) begin
        rd_data_d = 8'(shadow_q[k*GAIN_W +: GAIN_W]);
      end
    end
  end

  // State registers; reset discards any in-flight transaction without a commit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idle_cnt_q  <= '0;
      ptr_q       <= 8'd0;
      ptr_valid_q <= 1'b0;
      dirty_q     <= 1'b0;
      shadow_q    <= '0;
      active_q    <= '0;
      upd_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_range_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      ptr_q       <= ptr_d;
      ptr_valid_q <= ptr_valid_d;
      dirty_q     <= dirty_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      upd_q       <= upd_d;
      busy_q      <= busy_d;
      err_range_q <= err_range_d;
      err_ovf_q   <= err_ovf_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign gain_bus      = active_q;
  assign gains_updated = upd_q;
  assign busy          = busy_q;
  assign err_range     = err_range_q;
  assign err_overflow  = err_ovf_q;
  assign i2c_rd_data   = rd_data_q;

endmodule

// File: tb/tb_eq_gain_regbank_ctrl.sv
// Bench for eq_gain_regbank_ctrl: directed scenarios followed by randomized
// transactions. A transaction-level model of the register bank supplies every
// expected value.
module tb_eq_gain_regbank_ctrl;

  localparam int NB   = 10;
  localparam int GW   = 8;
  localparam int MAXG = 24;
  localparam int TO   = 1024;

  logic             clk;
  logic             reset_n;
  logic             i2c_start;
  logic [7:0]       i2c_data;
  logic             i2c_data_valid;
  logic [7:0]       i2c_rd_data;
  logic             sample_tick;
  logic             err_clr;
  logic [NB*GW-1:0] gain_bus;
  logic             gains_updated;
  logic             busy;
  logic             err_range;
  logic             err_overflow;

  eq_gain_regbank_ctrl #(
    .NUM_BANDS    (NB),
    .GAIN_W       (GW),
    .MAX_GAIN     (8'd24),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i2c_start      (i2c_start),
    .i2c_data       (i2c_data),
    .i2c_data_valid (i2c_data_valid),
    .i2c_rd_data    (i2c_rd_data),
    .sample_tick    (sample_tick),
    .err_clr        (err_clr),
    .gain_bus       (gain_bus),
    .gains_updated  (gains_updated),
    .busy           (busy),
    .err_range      (err_range),
    .err_overflow   (err_overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;

  // Count every gains_updated pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (gains_updated === 1'b1) upd_cnt++;
  end

  // Reference model: register bank at transaction level
  int m_shadow [NB];
  int m_active [NB];
  int m_ptr;
  bit m_ok;
  bit m_dirty;
  int m_phase;   // 0: no transaction, 1: expecting pointer, 2: data bytes
  bit m_erange;
  bit m_eovf;
  int m_commits;

  function automatic void model_reset();
    for (int k = 0; k < NB; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    m_ptr = 0; m_ok = 0; m_dirty = 0; m_phase = 0; m_erange = 0; m_eovf = 0;
  endfunction

  function automatic void model_byte(int b);
    if (m_phase == 1) begin
      m_ptr = b;
      m_ok  = (b >= 1) && (b <= NB);
      if (!m_ok) m_erange = 1;
      m_phase = 2;
    end else if (m_phase == 2 && m_ok) begin
      if (m_ptr <= NB) begin
        m_shadow[m_ptr-1] = (b > MAXG) ? MAXG : b;
        m_dirty = 1;
        m_ptr++;
      end else begin
        m_eovf = 1;
      end
    end
  endfunction

  function automatic logic [NB*GW-1:0] pack_active();
    logic [NB*GW-1:0] v;
    for (int k = 0; k < NB; k++) v[k*GW +: GW] = GW'(m_active[k]);
    return v;
  endfunction

  function automatic logic [7:0] model_rd();
    if (m_ok && m_ptr >= 1 && m_ptr <= NB) return 8'(m_shadow[m_ptr-1]);
    return 8'h00;
  endfunction

  // Scoreboard comparison point
  task automatic chk(input string tag, input logic [NB*GW-1:0] obs, input logic [NB*GW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "/gain_bus"}, gain_bus, pack_active());
    chk({tag, "/busy"}, 80'(busy), 80'((m_phase != 0) || m_dirty));
    chk({tag, "/err_range"}, 80'(err_range), 80'(m_erange));
    chk({tag, "/err_overflow"}, 80'(err_overflow), 80'(m_eovf));
    chk({tag, "/rd_data"}, 80'(i2c_rd_data), 80'(model_rd()));
    chk({tag, "/upd_count"}, 80'(upd_cnt), 80'(m_commits));
  endtask

  // Driver tasks
  task automatic do_start();
    @(negedge clk);
    i2c_start = 1'b1;
    @(negedge clk);
    i2c_start = 1'b0;
    m_phase = 1;
  endtask

  task automatic send_byte(input int b, input bit with_clr);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    i2c_data       = 8'(b);
    i2c_data_valid = 1'b1;
    err_clr        = with_clr;
    @(negedge clk);
    i2c_data_valid = 1'b0;
    err_clr        = 1'b0;
    if (with_clr) begin
      m_erange = 0;
      m_eovf   = 0;
    end
    model_byte(b);
  endtask

  task automatic start_with_byte(input int b);
    @(negedge clk);
    i2c_start      = 1'b1;
    i2c_data       = 8'(b);
    i2c_data_valid = 1'b1;
    @(negedge clk);
    i2c_start      = 1'b0;
    i2c_data_valid = 1'b0;
    m_phase = 1;
  endtask

  task automatic go_idle();
    repeat (TO + 8) @(negedge clk);
    m_phase = 0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_erange = 0;
    m_eovf   = 0;
  endtask

  task automatic tick(input string tag, input bit with_start);
    bit will;
    will = (m_phase == 0) && m_dirty;
    @(negedge clk);
    sample_tick = 1'b1;
    i2c_start   = with_start;
    @(negedge clk);
    sample_tick = 1'b0;
    i2c_start   = 1'b0;
    if (will) begin
      for (int k = 0; k < NB; k++) m_active[k] = m_shadow[k];
      m_dirty = 0;
      m_commits++;
    end
    if (with_start) m_phase = 1;
    chk({tag, "/upd_pulse"}, 80'(gains_updated), 80'(will));
    chk({tag, "/gain_at_upd"}, gain_bus, pack_active());
    @(negedge clk);
    chk({tag, "/upd_single"}, 80'(gains_updated), 80'(0));
  endtask

  initial begin
    int len;
    int p;
    reset_n        = 1'b0;
    i2c_start      = 1'b0;
    i2c_data       = 8'h00;
    i2c_data_valid = 1'b0;
    sample_tick    = 1'b0;
    err_clr        = 1'b0;
    m_commits      = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset/gain_bus", gain_bus, 80'(0));
    chk("reset/busy", 80'(busy), 80'(0));
    chk("reset/rd_data", 80'(i2c_rd_data), 80'(0));
    reset_n = 1'b1;
    check_all("post_reset");

    // Single write
    do_start();
    send_byte(8'h07, 0);
    send_byte(8'h11, 0);
    check_all("single_mid");
    go_idle();
    check_all("single_idle");
    tick("single_tick", 0);
    check_all("single_done");

    // Burst write of 1..10
    do_start();
    send_byte(8'h01, 0);
    for (int i = 1; i <= NB; i++) send_byte(i, 0);
    go_idle();
    check_all("burst_pre_tick");
    tick("burst_tick", 0);
    check_all("burst_done");

    // Overflow past the last band
    do_start();
    send_byte(8'h08, 0);
    send_byte(14, 0);
    send_byte(15, 0);
    send_byte(16, 0);
    send_byte(99, 0);
    go_idle();
    tick("ovf_tick", 0);
    check_all("ovf_done");
    clear_errs();
    check_all("ovf_cleared");

    // Range errors, no commit without dirty data
    do_start();
    send_byte(8'h0B, 0);
    send_byte(5, 0);
    go_idle();
    check_all("range_idle");
    tick("range_tick", 0);
    clear_errs();
    check_all("range_cleared");
    do_start();
    send_byte(8'h00, 0);
    send_byte(7, 0);
    go_idle();
    check_all("range_zero");
    // Clear coinciding with a new range error: the error wins
    do_start();
    send_byte(8'h0C, 1);
    go_idle();
    check_all("range_vs_clr");
    clear_errs();

    // Clamp plus back-to-back transactions, one commit
    do_start();
    send_byte(8'h03, 0);
    send_byte(8'hFF, 0);
    repeat (20) @(negedge clk);
    do_start();
    send_byte(8'h04, 0);
    send_byte(12, 0);
    tick("b2b_busy_tick", 0);
    go_idle();
    tick("b2b_tick", 0);
    check_all("b2b_done");

    // START and sample_tick in the same cycle: commit still happens
    do_start();
    send_byte(8'h02, 0);
    send_byte($urandom_range(0, 255), 0);
    go_idle();
    tick("start_tick", 1);
    send_byte(8'h09, 0);
    send_byte($urandom_range(0, 255), 0);
    go_idle();
    tick("start_tick_next", 0);
    check_all("start_tick_done");

    // START colliding with a data byte: the byte is ignored
    start_with_byte(8'h05);
    send_byte(8'h06, 0);
    send_byte(3, 0);
    go_idle();
    tick("collide_tick", 0);
    check_all("collide_done");

    // Reset mid-burst discards everything, then a full burst commits
    do_start();
    send_byte(8'h01, 0);
    for (int i = 0; i < 3; i++) send_byte($urandom_range(0, 255), 0);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_all("midburst_reset");
    do_start();
    send_byte(8'h01, 0);
    for (int i = 0; i < NB; i++) send_byte($urandom_range(0, 255), 0);
    go_idle();
    tick("after_reset_tick", 0);
    check_all("after_reset_done");

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      do_start();
      p   = $urandom_range(0, 12);
      len = $urandom_range(0, 6);
      send_byte(p, 0);
      for (int i = 0; i < len; i++) send_byte($urandom_range(0, 255), 0);
      if ($urandom_range(0, 3) == 0) tick("rnd_busy_tick", 0);
      go_idle();
      check_all("rnd_idle");
      tick("rnd_tick", 0);
      if (m_erange || m_eovf) clear_errs();
    end
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
